// File: rtl/glitch_pulse_gen.sv
// Burst glitch generator: one armed rising edge of trigger_in produces a programmed
// train of pulse_count pulses (pulse_width high, pulse_gap low) on glitch_out.
module glitch_pulse_gen #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger_in,
  input  logic [CNT_W-1:0] pulse_width,
  input  logic [CNT_W-1:0] pulse_gap,
  input  logic [NUM_W-1:0] pulse_count,
  input  logic             set_config,
  input  logic             arm,
  input  logic             abort,
  output logic             armed,
  output logic             busy,
  output logic             done,
  output logic             glitch_out
);

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    PULSE,
    GAP,
    DONE
  } state_t;

  state_t state, state_next;

  logic             trig_q;
  logic             rise;
  logic             cfg_en;

  logic [CNT_W-1:0] cfg_width;
  logic [CNT_W-1:0] cfg_gap;
  logic [NUM_W-1:0] cfg_count;

  logic [CNT_W-1:0] width_cnt, width_cnt_next;
  logic [CNT_W-1:0] gap_cnt, gap_cnt_next;
  logic [NUM_W-1:0] remaining, remaining_next;

  assign rise   = trigger_in & ~trig_q;
  assign cfg_en = set_config & ((state == IDLE) | (state == ARMED));

  // Trigger history is tracked in every state, so a level that is already high
  // when the block arms never looks like a fresh edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      trig_q <= 1'b0;
    end else begin
      trig_q <= trigger_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cfg_width <= CNT_W'(1);
      cfg_gap   <= CNT_W'(1);
      cfg_count <= '0;
    end else if (cfg_en) begin
      cfg_width <= (pulse_width == '0) ? CNT_W'(1) : pulse_width;
      cfg_gap   <= (pulse_gap == '0) ? CNT_W'(1) : pulse_gap;
      cfg_count <= pulse_count;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      width_cnt <= '0;
      gap_cnt   <= '0;
      remaining <= '0;
    end else begin
      state     <= state_next;
      width_cnt <= width_cnt_next;
      gap_cnt   <= gap_cnt_next;
      remaining <= remaining_next;
    end
  end

  // Counters run down to 1 rather than 0 so the full range of each field is usable.
  always_comb begin
    state_next     = state;
    width_cnt_next = width_cnt;
    gap_cnt_next   = gap_cnt;
    remaining_next = remaining;
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (arm) state_next = ARMED;
        end
        ARMED: begin
          if (rise) begin
            if (cfg_count != '0) begin
              state_next     = PULSE;
              width_cnt_next = cfg_width;
              remaining_next = cfg_count;
            end else begin
              state_next = DONE;
            end
          end
        end
        PULSE: begin
          if (width_cnt == CNT_W'(1)) begin
            if (remaining == NUM_W'(1)) begin
              state_next = DONE;
            end else begin
              state_next     = GAP;
              remaining_next = remaining - NUM_W'(1);
              gap_cnt_next   = cfg_gap;
            end
          end else begin
            width_cnt_next = width_cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == CNT_W'(1)) begin
            state_next     = PULSE;
            width_cnt_next = cfg_width;
          end else begin
            gap_cnt_next = gap_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          state_next = IDLE;
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  // Abort clears the outputs on the same edge the state returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      glitch_out <= 1'b0;
      armed      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      glitch_out <= (state == PULSE);
      armed      <= (state == ARMED);
      busy       <= (state == PULSE) || (state == GAP);
      done       <= (state == DONE);
    end
  end

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Directed bench for glitch_pulse_gen: per-edge output histories of each burst are
// compared against hand-derived bit patterns (bit i = sample after the i-th edge from the rise).
module tb_glitch_pulse_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trigger_in;
  logic [15:0] pulse_width;
  logic [15:0] pulse_gap;
  logic [7:0]  pulse_count;
  logic        set_config;
  logic        arm;
  logic        abort;
  logic        armed;
  logic        busy;
  logic        done;
  logic        glitch_out;

  int checks   = 0;
  int failures = 0;
  int excl_err = 0;

  logic [31:0] gv, dv, av, bv;
  logic        acc;

  glitch_pulse_gen #(
    .CNT_W(16),
    .NUM_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .trigger_in (trigger_in),
    .pulse_width(pulse_width),
    .pulse_gap  (pulse_gap),
    .pulse_count(pulse_count),
    .set_config (set_config),
    .arm        (arm),
    .abort      (abort),
    .armed      (armed),
    .busy       (busy),
    .done       (done),
    .glitch_out (glitch_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(armed) + int'(busy) + int'(done) > 1) excl_err++;
  endtask

  task automatic load_cfg(input logic [15:0] w, input logic [15:0] g, input logic [7:0] c);
    pulse_width = w;
    pulse_gap   = g;
    pulse_count = c;
    set_config  = 1'b1;
    tick();
    set_config  = 1'b0;
  endtask

  task automatic do_arm();
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  // Raises trigger_in so the first sampled edge is the rise edge; optional one-cycle
  // abort / set_config / reset pulses are driven after sample k, taking effect at edge k+1.
  task automatic run_burst(input int n, input int abort_at, input int cfg_at, input int rst_at);
    gv = '0;
    dv = '0;
    av = '0;
    bv = '0;
    trigger_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      gv[i] = glitch_out;
      dv[i] = done;
      av[i] = armed;
      bv[i] = busy;
      abort      = (i == abort_at);
      set_config = (i == cfg_at);
      rst_n      = (i != rst_at);
    end
    trigger_in = 1'b0;
    abort      = 1'b0;
    set_config = 1'b0;
    rst_n      = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    trigger_in = 1'b0;
    pulse_width = '0;
    pulse_gap = '0;
    pulse_count = '0;
    set_config = 1'b0;
    arm = 1'b0;
    abort = 1'b0;
    tick();
    tick();
    check("rst_outs", {28'd0, glitch_out, armed, busy, done}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Width 3, gap 2, count 2.
    load_cfg(16'd3, 16'd2, 8'd2);
    do_arm();
    run_burst(16, -1, -1, -1);
    check("b1_glitch", gv, 32'h0000_01CE);
    check("b1_done",   dv, 32'h0000_0200);
    check("b1_armed",  av, 32'h0000_0001);
    check("b1_busy",   bv, 32'h0000_01FE);

    // Zero width/gap stored as 1.
    load_cfg(16'd0, 16'd0, 8'd3);
    do_arm();
    run_burst(10, -1, -1, -1);
    check("b2_glitch", gv, 32'h0000_002A);
    check("b2_done",   dv, 32'h0000_0040);
    check("b2_busy",   bv, 32'h0000_003E);

    // Count 0: done only, then back to IDLE (an unarmed edge does nothing).
    load_cfg(16'd3, 16'd2, 8'd0);
    do_arm();
    run_burst(6, -1, -1, -1);
    check("c0_glitch", gv, 32'h0);
    check("c0_done",   dv, 32'h0000_0002);
    tick();
    run_burst(6, -1, -1, -1);
    check("c0_idle", gv | dv | av | bv, 32'h0);

    // Trigger already high at arm: no fire until a fresh edge.
    load_cfg(16'd2, 16'd1, 8'd1);
    trigger_in = 1'b1;
    tick();
    tick();
    do_arm();
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      acc = acc | glitch_out | busy | done;
    end
    check("lvl_nofire", {31'd0, acc}, 32'h0);
    check("lvl_armed",  {31'd0, armed}, 32'h1);
    trigger_in = 1'b0;
    tick();
    run_burst(6, -1, -1, -1);
    check("lvl_glitch", gv, 32'h0000_0006);
    check("lvl_done",   dv, 32'h0000_0008);

    // Abort on the 4th high cycle of a width-10 pulse; config write mid-burst ignored.
    load_cfg(16'd10, 16'd2, 8'd2);
    do_arm();
    pulse_width = 16'd1;
    pulse_gap   = 16'd1;
    pulse_count = 8'd1;
    run_burst(12, 4, 2, -1);
    check("ab_glitch", gv, 32'h0000_001E);
    check("ab_busy",   bv, 32'h0000_001E);
    check("ab_done",   dv, 32'h0);
    check("ab_armed",  av, 32'h0000_0001);
    do_arm();
    run_burst(28, -1, -1, -1);
    check("old_glitch", gv, 32'h007F_E7FE);
    check("old_done",   dv, 32'h0080_0000);

    // Reset during GAP, then count is back to 0.
    load_cfg(16'd3, 16'd2, 8'd2);
    do_arm();
    run_burst(8, -1, -1, 4);
    check("rg_glitch", gv, 32'h0000_000E);
    check("rg_busy",   bv, 32'h0000_001E);
    check("rg_done",   dv, 32'h0);
    do_arm();
    run_burst(6, -1, -1, -1);
    check("rg_c0_glitch", gv, 32'h0);
    check("rg_c0_done",   dv, 32'h0000_0002);

    // Arm and rise on the same edge: armed, rise not consumed; abort from ARMED.
    tick();
    arm = 1'b1;
    trigger_in = 1'b1;
    tick();
    arm = 1'b0;
    acc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      acc = acc | glitch_out | busy | done;
    end
    check("ar_nofire", {31'd0, acc}, 32'h0);
    check("ar_armed",  {31'd0, armed}, 32'h1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("ar_abort", {28'd0, glitch_out, armed, busy, done}, 32'h0);
    trigger_in = 1'b0;
    tick();
    run_burst(6, -1, -1, -1);
    check("ar_idle", gv | dv | av | bv, 32'h0);

    check("exclusive", excl_err, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
